// File: rtl/wb_retire_queue.sv
// In-order writeback/retire queue: buffers completed instructions, retires one per cycle
// to the regfile and commit-trace ports, and forwards buffered results to two lookups.

module wb_retire_queue_chk #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input logic          clk_i,
    input logic          rst_i,
    input logic [CW-1:0] count_q,
    input logic          push,
    input logic          pop
);
    // Occupancy stays within bounds and the handshake never over/underflows.
    a_count_range: assert property (@(posedge clk_i) disable iff (rst_i)
        count_q <= CW'(DEPTH));
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && (count_q == CW'(DEPTH))));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(pop && (count_q == CW'(0))));
endmodule

module wb_retire_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int REG_AW = 5
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [DATA_W-1:0]          in_pc_i,
    input  logic [DATA_W-1:0]          in_instr_i,
    input  logic [DATA_W-1:0]          in_result_i,
    input  logic [REG_AW-1:0]          in_rd_i,
    input  logic                       in_we_i,
    input  logic                       wb_stall_i,
    output logic                       wr_en_o,
    output logic [REG_AW-1:0]          wr_addr_o,
    output logic [DATA_W-1:0]          wr_data_o,
    output logic                       commit_valid_o,
    output logic [DATA_W-1:0]          commit_pc_o,
    output logic [DATA_W-1:0]          commit_instr_o,
    output logic [DATA_W-1:0]          commit_result_o,
    input  logic [REG_AW-1:0]          fwd_rs1_addr_i,
    output logic                       fwd_rs1_hit_o,
    output logic [DATA_W-1:0]          fwd_rs1_data_o,
    input  logic [REG_AW-1:0]          fwd_rs2_addr_i,
    output logic                       fwd_rs2_hit_o,
    output logic [DATA_W-1:0]          fwd_rs2_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] result;
        logic [REG_AW-1:0] rd;
        logic              we;
    } entry_t;

    entry_t         mem_q [DEPTH];
    entry_t         mem_d [DEPTH];
    entry_t         in_entry;
    entry_t         head_entry;
    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;
    logic           push;
    logic           pop;

    assign in_entry   = '{pc: in_pc_i, instr: in_instr_i, result: in_result_i,
                          rd: in_rd_i, we: in_we_i};
    assign head_entry = mem_q[head_q];

    // Ready depends only on registered occupancy, so a full queue never passes through.
    assign in_ready_o = !rst_i && (count_q != CW'(DEPTH));
    assign push       = in_valid_i && in_ready_o;
    assign pop        = !rst_i && (count_q != CW'(0)) && !wb_stall_i;

    // Pointer, occupancy and storage next-state.
    always_comb begin
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(push);
        count_d = count_q + CW'(push) - CW'(pop);
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = (push && (tail_q == PW'(i))) ? in_entry : mem_q[i];
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are don't-care after reset.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    assign commit_valid_o  = pop;
    assign commit_pc_o     = pop ? head_entry.pc     : '0;
    assign commit_instr_o  = pop ? head_entry.instr  : '0;
    assign commit_result_o = pop ? head_entry.result : '0;
    assign wr_en_o         = pop && head_entry.we && (head_entry.rd != '0);
    assign wr_addr_o       = pop ? head_entry.rd     : '0;
    assign wr_data_o       = pop ? head_entry.result : '0;
    assign count_o         = rst_i ? '0 : count_q;

    // Forwarding: scan oldest to youngest so the youngest match wins; the
    // retiring head still counts because the regfile only updates at the edge.
    always_comb begin : fwd_scan
        logic [PW-1:0] idx;
        logic          live;
        fwd_rs1_hit_o  = 1'b0;
        fwd_rs1_data_o = '0;
        fwd_rs2_hit_o  = 1'b0;
        fwd_rs2_data_o = '0;
        idx            = '0;
        live           = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            idx  = head_q + PW'(i);
            live = !rst_i && (CW'(i) < count_q) && mem_q[idx].we;
            if (live && (fwd_rs1_addr_i != '0) && (mem_q[idx].rd == fwd_rs1_addr_i)) begin
                fwd_rs1_hit_o  = 1'b1;
                fwd_rs1_data_o = mem_q[idx].result;
            end else begin
                fwd_rs1_hit_o  = fwd_rs1_hit_o;
            end
            if (live && (fwd_rs2_addr_i != '0) && (mem_q[idx].rd == fwd_rs2_addr_i)) begin
                fwd_rs2_hit_o  = 1'b1;
                fwd_rs2_data_o = mem_q[idx].result;
            end else begin
                fwd_rs2_hit_o  = fwd_rs2_hit_o;
            end
        end
    end

    wb_retire_queue_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .count_q (count_q),
        .push    (push),
        .pop     (pop)
    );
endmodule

// File: tb/tb_wb_retire_queue.sv
// Directed self-checking bench for wb_retire_queue (DEPTH=4) with hand-computed expectations.

module tb_wb_retire_queue;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int REG_AW = 5;
    localparam int CW     = $clog2(DEPTH+1);

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_pc_i, in_instr_i, in_result_i;
    logic [REG_AW-1:0] in_rd_i;
    logic              in_we_i;
    logic              wb_stall_i;
    logic              wr_en_o;
    logic [REG_AW-1:0] wr_addr_o;
    logic [DATA_W-1:0] wr_data_o;
    logic              commit_valid_o;
    logic [DATA_W-1:0] commit_pc_o, commit_instr_o, commit_result_o;
    logic [REG_AW-1:0] fwd_rs1_addr_i, fwd_rs2_addr_i;
    logic              fwd_rs1_hit_o, fwd_rs2_hit_o;
    logic [DATA_W-1:0] fwd_rs1_data_o, fwd_rs2_data_o;
    logic [CW-1:0]     count_o;

    int checks = 0;
    int errors = 0;

    wb_retire_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .REG_AW(REG_AW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_pc_i(in_pc_i), .in_instr_i(in_instr_i), .in_result_i(in_result_i),
        .in_rd_i(in_rd_i), .in_we_i(in_we_i), .wb_stall_i(wb_stall_i),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .commit_valid_o(commit_valid_o), .commit_pc_o(commit_pc_o),
        .commit_instr_o(commit_instr_o), .commit_result_o(commit_result_o),
        .fwd_rs1_addr_i(fwd_rs1_addr_i), .fwd_rs1_hit_o(fwd_rs1_hit_o),
        .fwd_rs1_data_o(fwd_rs1_data_o),
        .fwd_rs2_addr_i(fwd_rs2_addr_i), .fwd_rs2_hit_o(fwd_rs2_hit_o),
        .fwd_rs2_data_o(fwd_rs2_data_o),
        .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change 1 time unit after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] res,
                         input logic [4:0] rd, input logic we);
        in_valid_i  = v;
        in_pc_i     = pc;
        in_instr_i  = pc ^ 32'h0000_0013;
        in_result_i = res;
        in_rd_i     = rd;
        in_we_i     = we;
    endtask

    initial begin
        rst_i = 1'b1;
        wb_stall_i = 1'b0;
        fwd_rs1_addr_i = 5'd0;
        fwd_rs2_addr_i = 5'd0;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0);

        // Reset and empty
        step(); step();
        check_val("rst_ready", 64'(in_ready_o), 64'd0);
        check_val("rst_count", 64'(count_o), 64'd0);
        rst_i = 1'b0;
        #1;
        check_val("empty_count", 64'(count_o), 64'd0);
        check_val("empty_ready", 64'(in_ready_o), 64'd1);
        check_val("empty_wr_en", 64'(wr_en_o), 64'd0);
        check_val("empty_commit", 64'(commit_valid_o), 64'd0);

        // Single instruction
        drive(1'b1, 32'h100, 32'd5, 5'd1, 1'b1);
        in_instr_i = 32'h0050_0093;
        fwd_rs1_addr_i = 5'd1;
        #1;
        check_val("single_nobypass", 64'(commit_valid_o), 64'd0);
        check_val("single_push_nofwd", 64'(fwd_rs1_hit_o), 64'd0);
        step();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        #1;
        check_val("single_commit", 64'(commit_valid_o), 64'd1);
        check_val("single_wr_en", 64'(wr_en_o), 64'd1);
        check_val("single_wr_addr", 64'(wr_addr_o), 64'd1);
        check_val("single_wr_data", 64'(wr_data_o), 64'd5);
        check_val("single_pc", 64'(commit_pc_o), 64'h100);
        check_val("single_instr", 64'(commit_instr_o), 64'h0050_0093);
        check_val("single_count1", 64'(count_o), 64'd1);
        check_val("single_fwd_head", 64'(fwd_rs1_hit_o), 64'd1);
        check_val("single_fwd_data", 64'(fwd_rs1_data_o), 64'd5);
        step();
        check_val("single_count0", 64'(count_o), 64'd0);
        check_val("single_done", 64'(commit_valid_o), 64'd0);
        fwd_rs1_addr_i = 5'd0;

        // Fill and backpressure
        wb_stall_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h200 + 32'(4*k), 32'(k), 5'd9, 1'b1);
            #1;
            check_val("fill_ready", 64'(in_ready_o), (k < 4) ? 64'd1 : 64'd0);
            check_val("fill_stall_commit", 64'(commit_valid_o), 64'd0);
            step();
        end
        wb_stall_i = 1'b0;
        #1;
        check_val("full_count", 64'(count_o), 64'd4);
        check_val("full_ready", 64'(in_ready_o), 64'd0);
        check_val("full_pop0", 64'(commit_pc_o), 64'h200);
        step();
        check_val("drain_ready", 64'(in_ready_o), 64'd1);
        check_val("drain_pop1", 64'(commit_pc_o), 64'h204);
        check_val("drain_count3a", 64'(count_o), 64'd3);
        step();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        #1;
        check_val("drain_pop2", 64'(commit_pc_o), 64'h208);
        check_val("drain_count3b", 64'(count_o), 64'd3);
        step();
        check_val("drain_pop3", 64'(commit_pc_o), 64'h20C);
        check_val("drain_count2", 64'(count_o), 64'd2);
        step();
        check_val("drain_pop4", 64'(commit_pc_o), 64'h210);
        check_val("drain_count1", 64'(count_o), 64'd1);
        step();
        check_val("drain_empty", 64'(count_o), 64'd0);

        // Wrap-around streaming
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'(4*k), 32'(k + 100), 5'(k % 8 + 1), 1'b1);
            #1;
            if (k > 0) begin
                check_val("wrap_pc", 64'(commit_pc_o), 64'(4*(k-1)));
                check_val("wrap_count", 64'(count_o), 64'd1);
            end
            step();
        end
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        #1;
        check_val("wrap_last_pc", 64'(commit_pc_o), 64'h24);
        check_val("wrap_last_data", 64'(wr_data_o), 64'd109);
        step();
        check_val("wrap_empty", 64'(count_o), 64'd0);

        // x0 and we=0
        drive(1'b1, 32'h300, 32'd7, 5'd0, 1'b1);
        step();
        drive(1'b1, 32'h304, 32'd9, 5'd3, 1'b0);
        fwd_rs1_addr_i = 5'd0;
        fwd_rs2_addr_i = 5'd3;
        #1;
        check_val("x0_commit", 64'(commit_valid_o), 64'd1);
        check_val("x0_wr_en", 64'(wr_en_o), 64'd0);
        check_val("x0_fwd_rs1", 64'(fwd_rs1_hit_o), 64'd0);
        step();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        #1;
        check_val("nowe_commit", 64'(commit_valid_o), 64'd1);
        check_val("nowe_wr_en", 64'(wr_en_o), 64'd0);
        check_val("nowe_fwd_rs2", 64'(fwd_rs2_hit_o), 64'd0);
        step();

        // Forwarding priority
        wb_stall_i = 1'b1;
        drive(1'b1, 32'h400, 32'hA, 5'd2, 1'b1);
        step();
        drive(1'b1, 32'h404, 32'hB, 5'd2, 1'b1);
        step();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        fwd_rs1_addr_i = 5'd2;
        fwd_rs2_addr_i = 5'd4;
        #1;
        check_val("fwd_rs1_hit", 64'(fwd_rs1_hit_o), 64'd1);
        check_val("fwd_rs1_young", 64'(fwd_rs1_data_o), 64'hB);
        check_val("fwd_rs2_miss", 64'(fwd_rs2_hit_o), 64'd0);
        wb_stall_i = 1'b0;
        #1;
        check_val("fwd_pop_a", 64'(wr_data_o), 64'hA);
        check_val("fwd_during_pop_a", 64'(fwd_rs1_data_o), 64'hB);
        step();
        check_val("fwd_head_b_hit", 64'(fwd_rs1_hit_o), 64'd1);
        check_val("fwd_head_b_data", 64'(fwd_rs1_data_o), 64'hB);
        step();
        check_val("fwd_after_miss", 64'(fwd_rs1_hit_o), 64'd0);
        check_val("fwd_after_count", 64'(count_o), 64'd0);

        // Mid-operation reset discards contents
        wb_stall_i = 1'b1;
        drive(1'b1, 32'h500, 32'h55, 5'd6, 1'b1);
        step(); step();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        rst_i = 1'b1;
        fwd_rs1_addr_i = 5'd6;
        #1;
        check_val("midrst_count", 64'(count_o), 64'd0);
        check_val("midrst_fwd", 64'(fwd_rs1_hit_o), 64'd0);
        step();
        rst_i = 1'b0;
        wb_stall_i = 1'b0;
        #1;
        check_val("midrst_after_count", 64'(count_o), 64'd0);
        check_val("midrst_after_commit", 64'(commit_valid_o), 64'd0);
        check_val("midrst_after_fwd", 64'(fwd_rs1_hit_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
